// File: rtl/layered_color_mapper.sv
// Layered colour mapper: composites NUM_SPRITES sprite layers over the maze
// walls and background, then applies game-mode recolouring (frightened
// ghosts, end-of-fright blinking, level-complete wall flash).
// Two-stage pipeline: stage 1 picks the winning layer, stage 2 recolours.
// Fixed latency of 2 clocks from inputs to VGA_*/out_valid.
module layered_color_mapper #(
    parameter int                     NUM_SPRITES     = 4,
    parameter int                     COLOR_W         = 8,
    parameter int                     PLAYFIELD_H     = 352,
    parameter logic [3*COLOR_W-1:0]   TRANSPARENT_KEY = 24'h000000,
    parameter int                     BLINK_FRAMES    = 8,
    parameter logic [3*COLOR_W-1:0]   WALL_RGB        = 24'hFF0000,
    parameter logic [3*COLOR_W-1:0]   BG_RGB          = 24'h3F007F,
    parameter logic [3*COLOR_W-1:0]   FRIGHT_RGB      = 24'h0000FF,
    parameter logic [3*COLOR_W-1:0]   FLASH_RGB       = 24'hFFFFFF
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               pixel_valid,
    input  logic                               frame_start,
    input  logic [9:0]                         DrawX,
    input  logic [9:0]                         DrawY,
    input  logic [NUM_SPRITES-1:0]             sprite_hit,
    input  logic [NUM_SPRITES*3*COLOR_W-1:0]   sprite_rgb,
    input  logic                               is_wall,
    input  logic                               frightened,
    input  logic                               fright_ending,
    input  logic                               wall_flash,
    output logic [COLOR_W-1:0]                 VGA_R,
    output logic [COLOR_W-1:0]                 VGA_G,
    output logic [COLOR_W-1:0]                 VGA_B,
    output logic                               out_valid
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [31:0]     PF_H    = 32'(PLAYFIELD_H);

    // Which layer won the pixel at stage 1.
    typedef enum logic [1:0] {
        SRC_BG     = 2'd0,
        SRC_WALL   = 2'd1,
        SRC_SPRITE = 2'd2
    } src_t;

    // Horizontal position plays no part in colour selection; the sprite
    // readers have already resolved it into sprite_hit/sprite_rgb.
    logic [9:0] unused_drawx;
    assign unused_drawx = DrawX;

    // Blink timer state
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    // Stage-1 resolve combinational results
    logic             hit_any;
    logic [IDX_W-1:0] win_idx;
    logic [PIX_W-1:0] win_rgb;
    logic             wall_here;
    src_t             src_next;

    // Stage-1 registers
    logic             s1_valid;
    src_t             s1_src;
    logic [IDX_W-1:0] s1_idx;
    logic [PIX_W-1:0] s1_rgb;
    logic             s1_frightened;
    logic             s1_fright_ending;
    logic             s1_wall_flash;

    // Stage-2 recolour combinational result
    logic [PIX_W-1:0] rgb_next;
    logic             ghost_fright;

    // Frame counter: wraps every BLINK_FRAMES frame_start pulses and flips
    // blink_phase on the wrap, independent of any mode input.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Priority pick: scan from the highest index down so the lowest index
    // with a non-transparent hit is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        win_idx = '0;
        win_rgb = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (sprite_hit[i] && (sprite_rgb[i*PIX_W +: PIX_W] != TRANSPARENT_KEY)) begin
                hit_any = 1'b1;
                win_idx = IDX_W'(i);
                win_rgb = sprite_rgb[i*PIX_W +: PIX_W];
            end
        end
    end

    // Source classification: sprite beats wall, walls are clipped to the
    // playfield rows, everything else is background.
    always_comb begin
        wall_here = is_wall && ({22'd0, DrawY} < PF_H);
        src_next  = SRC_BG;
        if (hit_any) begin
            src_next = SRC_SPRITE;
        end else if (wall_here) begin
            src_next = SRC_WALL;
        end
    end

    // Stage-1 register: winning layer plus the mode bits that travel with it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid         <= 1'b0;
            s1_src           <= SRC_BG;
            s1_idx           <= '0;
            s1_rgb           <= '0;
            s1_frightened    <= 1'b0;
            s1_fright_ending <= 1'b0;
            s1_wall_flash    <= 1'b0;
        end else begin
            s1_valid         <= pixel_valid;
            s1_src           <= src_next;
            s1_idx           <= win_idx;
            s1_rgb           <= win_rgb;
            s1_frightened    <= frightened;
            s1_fright_ending <= fright_ending;
            s1_wall_flash    <= wall_flash;
        end
    end

    // Recolour using the live blink phase; Pac-Man (index 0) is never
    // recoloured, and invalid pixels are blanked to black.
    always_comb begin
        ghost_fright = (s1_idx != '0) && s1_frightened;
        rgb_next     = BG_RGB;
        case (s1_src)
            SRC_SPRITE: begin
                if (ghost_fright) begin
                    rgb_next = (s1_fright_ending && blink_phase) ? FLASH_RGB : FRIGHT_RGB;
                end else begin
                    rgb_next = s1_rgb;
                end
            end
            SRC_WALL: begin
                rgb_next = (s1_wall_flash && blink_phase) ? FLASH_RGB : WALL_RGB;
            end
            default: begin
                rgb_next = BG_RGB;
            end
        endcase
        if (!s1_valid) begin
            rgb_next = '0;
        end
    end

    // Stage-2 output registers driving the VGA DAC.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            out_valid <= 1'b0;
        end else begin
            VGA_R     <= rgb_next[2*COLOR_W +: COLOR_W];
            VGA_G     <= rgb_next[COLOR_W +: COLOR_W];
            VGA_B     <= rgb_next[0 +: COLOR_W];
            out_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_layered_color_mapper.sv
// Bench for layered_color_mapper: directed steps from the test plan followed
// by a randomized run, all compared against a frame-counting reference model.
module tb_layered_color_mapper;

    localparam int N  = 4;
    localparam int BF = 8;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            pixel_valid = 1'b0;
    logic            frame_start = 1'b0;
    logic [9:0]      DrawX = '0;
    logic [9:0]      DrawY = '0;
    logic [N-1:0]    sprite_hit = '0;
    logic [N*24-1:0] sprite_rgb = '0;
    logic            is_wall = 1'b0;
    logic            frightened = 1'b0;
    logic            fright_ending = 1'b0;
    logic            wall_flash = 1'b0;
    logic [7:0]      VGA_R, VGA_G, VGA_B;
    logic            out_valid;

    int errors = 0;
    int checks = 0;

    // Reference state: total frame_start pulses seen since reset, and the
    // expected output for the pixel sampled on the previous edge.
    int          fs_count = 0;
    logic        exp_v = 1'b0;
    logic [23:0] exp_rgb = '0;

    layered_color_mapper dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .pixel_valid   (pixel_valid),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .sprite_hit    (sprite_hit),
        .sprite_rgb    (sprite_rgb),
        .is_wall       (is_wall),
        .frightened    (frightened),
        .fright_ending (fright_ending),
        .wall_flash    (wall_flash),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .out_valid     (out_valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Colour the spec's rules give for the current inputs at a given blink phase.
    function automatic logic [23:0] ref_pixel(input int phase);
        logic [23:0] c;
        if (!pixel_valid) return 24'h000000;
        for (int i = 0; i < N; i++) begin
            c = sprite_rgb[i*24 +: 24];
            if (sprite_hit[i] && c != 24'h000000) begin
                if (i == 0 || !frightened) return c;
                if (fright_ending && phase == 1) return 24'hFFFFFF;
                return 24'h0000FF;
            end
        end
        if (is_wall && DrawY < 10'd352) return (wall_flash && phase == 1) ? 24'hFFFFFF : 24'hFF0000;
        return 24'h3F007F;
    endfunction

    // One clock: model the pixel taken on this edge, then check the output
    // that belongs to the pixel taken on the previous edge.
    task automatic tick();
        logic        nv;
        logic [23:0] nrgb;
        @(posedge Clk);
        if (!Reset_n) begin
            fs_count = 0;
            nv       = 1'b0;
            nrgb     = '0;
        end else begin
            if (frame_start) fs_count++;
            nv   = pixel_valid;
            nrgb = ref_pixel((fs_count / BF) % 2);
        end
        #1;
        chk("out_valid", {23'd0, out_valid}, {23'd0, exp_v});
        chk("rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb);
        exp_v   = nv;
        exp_rgb = nrgb;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic set_spr(input int i, input logic [23:0] v);
        sprite_rgb[i*24 +: 24] = v;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        chk("reset_valid", {23'd0, out_valid}, 24'h0);

        // Release and first-pixel latency
        Reset_n     = 1'b1;
        pixel_valid = 1'b1;
        DrawY       = 10'd10;
        tick();
        chk("lat_plus1_valid", {23'd0, out_valid}, 24'h0);
        tick();
        chk("lat_plus2_valid", {23'd0, out_valid}, 24'h1);
        chk("lat_plus2_rgb", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);

        // Priority and transparency
        sprite_hit = 4'b0011;
        set_spr(0, 24'h000000);
        set_spr(1, 24'hFFB8FF);
        settle();
        chk("transparent_fallthrough", {VGA_R, VGA_G, VGA_B}, 24'hFFB8FF);
        set_spr(0, 24'hFFFF00);
        settle();
        chk("pacman_priority", {VGA_R, VGA_G, VGA_B}, 24'hFFFF00);

        // Wall clip at the playfield edge
        sprite_hit = '0;
        is_wall    = 1'b1;
        DrawY      = 10'd351;
        settle();
        chk("wall_row351", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
        DrawY = 10'd352;
        settle();
        chk("wall_row352", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);

        // Frightened ghost and end-of-fright blinking
        is_wall    = 1'b0;
        DrawY      = 10'd100;
        sprite_hit = 4'b0100;
        set_spr(2, 24'h00FFFF);
        frightened = 1'b1;
        settle();
        chk("ghost_fright", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);
        fright_ending = 1'b1;
        settle();
        chk("ghost_ending_phase0", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);
        pulses(BF);
        settle();
        chk("ghost_blink_on", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
        pulses(BF);
        settle();
        chk("ghost_blink_off", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);

        // Pac-Man ignores fright; wall flash alternates every BF frames
        sprite_hit = 4'b0001;
        pulses(BF);
        settle();
        chk("pacman_immune", {VGA_R, VGA_G, VGA_B}, 24'hFFFF00);
        pulses(BF);
        sprite_hit    = '0;
        frightened    = 1'b0;
        fright_ending = 1'b0;
        is_wall       = 1'b1;
        wall_flash    = 1'b1;
        settle();
        chk("wall_flash_phase0", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
        pulses(BF);
        settle();
        chk("wall_flash_phase1", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
        pulses(BF);
        settle();
        chk("wall_flash_back", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);

        // Blanking: alternating valid shows up two cycles later
        for (int k = 0; k < 12; k++) begin
            pixel_valid = k[0];
            tick();
        end
        pixel_valid = 1'b1;
        wall_flash  = 1'b0;
        settle();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            pixel_valid   = ($urandom_range(0, 3) != 0);
            frame_start   = ($urandom_range(0, 5) == 0);
            DrawX         = 10'($urandom);
            DrawY         = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(345, 358)) : 10'($urandom);
            sprite_hit    = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                set_spr(i, ($urandom_range(0, 3) == 0) ? 24'h000000 : 24'($urandom));
            end
            is_wall       = 1'($urandom);
            frightened    = 1'($urandom);
            fright_ending = 1'($urandom);
            wall_flash    = 1'($urandom);
            tick();
        end
        frame_start = 1'b0;

        // Mid-stream asynchronous reset with a valid pixel in flight
        pixel_valid = 1'b1;
        sprite_hit  = 4'b0001;
        set_spr(0, 24'h123456);
        tick();
        Reset_n = 1'b0;
        #1;
        chk("async_reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        chk("async_reset_valid", {23'd0, out_valid}, 24'h0);
        exp_v   = 1'b0;
        exp_rgb = '0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        chk("post_reset_plus1", {23'd0, out_valid}, 24'h0);
        tick();
        chk("post_reset_plus2", {VGA_R, VGA_G, VGA_B}, 24'h123456);
        pixel_valid = 1'b0;
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
